// File: rtl/int_issue_queue.sv
// Integer issue queue: in-order compacting buffer with CDB snoop and oldest-ready select.
// Optional zero-cycle CDB wakeup in the select path when ISSUE_Q_CDB_WAKEUP_EN is defined.
module int_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    input  logic [OPC_W-1:0]  disp_opcode,
    input  logic [TAG_W-1:0]  disp_rd_tag,
    input  logic              disp_rs1_valid,
    input  logic [TAG_W-1:0]  disp_rs1_tag,
    input  logic [DATA_W-1:0] disp_rs1_data,
    input  logic              disp_rs2_valid,
    input  logic [TAG_W-1:0]  disp_rs2_tag,
    input  logic [DATA_W-1:0] disp_rs2_data,
    output logic              queue_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              ready_int,
    input  logic              issue_int,
    output logic [OPC_W-1:0]  iss_opcode,
    output logic [TAG_W-1:0]  iss_rd_tag,
    output logic [DATA_W-1:0] iss_rs1_data,
    output logic [DATA_W-1:0] iss_rs2_data
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q, valid_d, rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
    logic [OPC_W-1:0]  opc_q [DEPTH];
    logic [OPC_W-1:0]  opc_d [DEPTH];
    logic [TAG_W-1:0]  rd_q [DEPTH];
    logic [TAG_W-1:0]  rd_d [DEPTH];
    logic [TAG_W-1:0]  rs1_tag_q [DEPTH];
    logic [TAG_W-1:0]  rs1_tag_d [DEPTH];
    logic [TAG_W-1:0]  rs2_tag_q [DEPTH];
    logic [TAG_W-1:0]  rs2_tag_d [DEPTH];
    logic [DATA_W-1:0] rs1_data_q [DEPTH];
    logic [DATA_W-1:0] rs1_data_d [DEPTH];
    logic [DATA_W-1:0] rs2_data_q [DEPTH];
    logic [DATA_W-1:0] rs2_data_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d, tail;
    logic [DEPTH-1:0]  fwd1, fwd2;
    logic [IDX_W-1:0]  sel;
    logic              sel_found, do_issue, accept;

    // fwd marks operands completed by this cycle's broadcast, before they are stored
    for (genvar g = 0; g < DEPTH; g++) begin : g_fwd
`ifdef ISSUE_Q_CDB_WAKEUP_EN
        assign fwd1[g] = valid_q[g] & ~rs1_rdy_q[g] & cdb_valid & (rs1_tag_q[g] == cdb_tag);
        assign fwd2[g] = valid_q[g] & ~rs2_rdy_q[g] & cdb_valid & (rs2_tag_q[g] == cdb_tag);
`else
        assign fwd1[g] = 1'b0;
        assign fwd2[g] = 1'b0;
`endif
    end

    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (rs1_rdy_q[i] || fwd1[i]) && (rs2_rdy_q[i] || fwd2[i])) begin
                sel_found = 1'b1;
                sel       = IDX_W'(i);
            end
        end
    end

    assign ready_int  = sel_found;
    assign queue_full = (count_q == CNT_W'(DEPTH));
    assign do_issue   = issue_int & sel_found;
    assign accept     = disp_valid & ~queue_full;
    assign tail       = do_issue ? count_q - CNT_W'(1) : count_q;

    always_comb begin
        iss_opcode   = '0;
        iss_rd_tag   = '0;
        iss_rs1_data = '0;
        iss_rs2_data = '0;
        if (sel_found) begin
            iss_opcode   = opc_q[sel];
            iss_rd_tag   = rd_q[sel];
            iss_rs1_data = fwd1[sel] ? cdb_data : rs1_data_q[sel];
            iss_rs2_data = fwd2[sel] ? cdb_data : rs2_data_q[sel];
        end
    end

    // Order matters: compact first, then snoop post-shift slots, then write the tail
    always_comb begin
        valid_d    = valid_q;
        rs1_rdy_d  = rs1_rdy_q;
        rs2_rdy_d  = rs2_rdy_q;
        opc_d      = opc_q;
        rd_d       = rd_q;
        rs1_tag_d  = rs1_tag_q;
        rs2_tag_d  = rs2_tag_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        count_d    = count_q;
        if (do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel) begin
                    valid_d[i]    = valid_q[i+1];
                    rs1_rdy_d[i]  = rs1_rdy_q[i+1];
                    rs2_rdy_d[i]  = rs2_rdy_q[i+1];
                    opc_d[i]      = opc_q[i+1];
                    rd_d[i]       = rd_q[i+1];
                    rs1_tag_d[i]  = rs1_tag_q[i+1];
                    rs2_tag_d[i]  = rs2_tag_q[i+1];
                    rs1_data_d[i] = rs1_data_q[i+1];
                    rs2_data_d[i] = rs2_data_q[i+1];
                end
            end
            valid_d[DEPTH-1]   = 1'b0;
            rs1_rdy_d[DEPTH-1] = 1'b0;
            rs2_rdy_d[DEPTH-1] = 1'b0;
        end
        if (cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_d[i] && !rs1_rdy_d[i] && rs1_tag_d[i] == cdb_tag) begin
                    rs1_rdy_d[i]  = 1'b1;
                    rs1_data_d[i] = cdb_data;
                end
                if (valid_d[i] && !rs2_rdy_d[i] && rs2_tag_d[i] == cdb_tag) begin
                    rs2_rdy_d[i]  = 1'b1;
                    rs2_data_d[i] = cdb_data;
                end
            end
        end
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tail == CNT_W'(i)) begin
                    valid_d[i]    = 1'b1;
                    opc_d[i]      = disp_opcode;
                    rd_d[i]       = disp_rd_tag;
                    rs1_tag_d[i]  = disp_rs1_tag;
                    rs2_tag_d[i]  = disp_rs2_tag;
                    rs1_rdy_d[i]  = disp_rs1_valid || (cdb_valid && disp_rs1_tag == cdb_tag);
                    rs2_rdy_d[i]  = disp_rs2_valid || (cdb_valid && disp_rs2_tag == cdb_tag);
                    rs1_data_d[i] = (!disp_rs1_valid && cdb_valid && disp_rs1_tag == cdb_tag)
                                    ? cdb_data : disp_rs1_data;
                    rs2_data_d[i] = (!disp_rs2_valid && cdb_valid && disp_rs2_tag == cdb_tag)
                                    ? cdb_data : disp_rs2_data;
                end
            end
        end
        case ({accept, do_issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            valid_d   = '0;
            rs1_rdy_d = '0;
            rs2_rdy_d = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opc_q[i]      <= '0;
                rd_q[i]       <= '0;
                rs1_tag_q[i]  <= '0;
                rs2_tag_q[i]  <= '0;
                rs1_data_q[i] <= '0;
                rs2_data_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            rs1_rdy_q  <= rs1_rdy_d;
            rs2_rdy_q  <= rs2_rdy_d;
            count_q    <= count_d;
            opc_q      <= opc_d;
            rd_q       <= rd_d;
            rs1_tag_q  <= rs1_tag_d;
            rs2_tag_q  <= rs2_tag_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue (default build): directed scenarios plus random traffic vs a queue model.
module tb_int_issue_queue;
    logic        clk = 1'b0;
    logic        rst, flush, disp_valid, disp_rs1_valid, disp_rs2_valid;
    logic [3:0]  disp_opcode;
    logic [5:0]  disp_rd_tag, disp_rs1_tag, disp_rs2_tag, cdb_tag;
    logic [31:0] disp_rs1_data, disp_rs2_data, cdb_data;
    logic        cdb_valid, issue_int, queue_full, ready_int;
    logic [3:0]  iss_opcode;
    logic [5:0]  iss_rd_tag;
    logic [31:0] iss_rs1_data, iss_rs2_data;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [3:0]  opc;
        logic [5:0]  rd;
        logic        r1;
        logic [5:0]  t1;
        logic [31:0] d1;
        logic        r2;
        logic [5:0]  t2;
        logic [31:0] d2;
    } ent_t;
    ent_t q[$];

    int_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_rd_tag(disp_rd_tag),
        .disp_rs1_valid(disp_rs1_valid), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_data(disp_rs1_data),
        .disp_rs2_valid(disp_rs2_valid), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_data(disp_rs2_data),
        .queue_full(queue_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ready_int(ready_int), .issue_int(issue_int),
        .iss_opcode(iss_opcode), .iss_rd_tag(iss_rd_tag),
        .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_sel();
        for (int k = 0; k < q.size(); k++)
            if (q[k].r1 && q[k].r2) return k;
        return -1;
    endfunction

    task automatic idle();
        flush = 0; disp_valid = 0; issue_int = 0; cdb_valid = 0;
        disp_opcode = 0; disp_rd_tag = 0;
        disp_rs1_valid = 0; disp_rs1_tag = 0; disp_rs1_data = 0;
        disp_rs2_valid = 0; disp_rs2_tag = 0; disp_rs2_data = 0;
        cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic set_disp(input logic [3:0] opc, input logic [5:0] rd,
                            input logic v1, input logic [5:0] t1, input logic [31:0] d1,
                            input logic v2, input logic [5:0] t2, input logic [31:0] d2);
        disp_valid = 1; disp_opcode = opc; disp_rd_tag = rd;
        disp_rs1_valid = v1; disp_rs1_tag = t1; disp_rs1_data = d1;
        disp_rs2_valid = v2; disp_rs2_tag = t2; disp_rs2_data = d2;
    endtask

    // Compare outputs with the model for the current inputs, then advance both one clock
    task automatic step();
        int   s;
        ent_t e;
        bit   was_full;
        #1;
        s = model_sel();
        e = '0;
        if (s >= 0) e = q[s];
        check("queue_full", queue_full, q.size() == 4);
        check("ready_int", ready_int, s >= 0);
        check("iss_opcode", iss_opcode, e.opc);
        check("iss_rd_tag", iss_rd_tag, e.rd);
        check("iss_rs1_data", iss_rs1_data, e.d1);
        check("iss_rs2_data", iss_rs2_data, e.d2);
        was_full = (q.size() == 4);
        if (flush) q.delete();
        else begin
            if (issue_int && s >= 0) q.delete(s);
            if (cdb_valid)
                for (int k = 0; k < q.size(); k++) begin
                    if (!q[k].r1 && q[k].t1 == cdb_tag) begin q[k].r1 = 1; q[k].d1 = cdb_data; end
                    if (!q[k].r2 && q[k].t2 == cdb_tag) begin q[k].r2 = 1; q[k].d2 = cdb_data; end
                end
            if (disp_valid && !was_full) begin
                e.opc = disp_opcode; e.rd = disp_rd_tag;
                e.t1 = disp_rs1_tag; e.t2 = disp_rs2_tag;
                e.r1 = disp_rs1_valid; e.d1 = disp_rs1_data;
                e.r2 = disp_rs2_valid; e.d2 = disp_rs2_data;
                if (!e.r1 && cdb_valid && e.t1 == cdb_tag) begin e.r1 = 1; e.d1 = cdb_data; end
                if (!e.r2 && cdb_valid && e.t2 == cdb_tag) begin e.r2 = 1; e.d2 = cdb_data; end
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 0;
        idle();
        @(negedge clk);
        #1;
        check("rst_queue_full", queue_full, 0);
        check("rst_ready_int", ready_int, 0);
        check("rst_iss_rd_tag", iss_rd_tag, 0);
        check("rst_iss_rs1", iss_rs1_data, 0);
        rst = 1;
        @(negedge clk);

        // Fill with four ready ops, then try a fifth
        for (int i = 1; i <= 4; i++) begin
            set_disp(4'(i), 6'(i), 1, 0, 32'(i * 16), 1, 0, 32'(i * 256));
            step();
        end
        #1;
        check("full_after_4", queue_full, 1);
        check("oldest_rd_tag", iss_rd_tag, 1);
        set_disp(4'd5, 6'd5, 1, 0, 32'h5, 1, 0, 32'h5);
        step();
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("drain_rd_tag", iss_rd_tag, 6'(i));
            issue_int = 1;
            step();
        end
        #1;
        check("fifth_dropped", ready_int, 0);

        // Younger ready op issues ahead of an older waiting one; wakeup next cycle
        set_disp(4'd1, 6'd1, 0, 6'd9, 0, 1, 0, 32'h11);
        step();
        set_disp(4'd2, 6'd2, 1, 0, 32'h22, 1, 0, 32'h23);
        step();
        #1;
        check("younger_first", iss_rd_tag, 2);
        issue_int = 1;
        step();
        cdb_valid = 1; cdb_tag = 9; cdb_data = 32'hAB;
        #1;
        check("waiting_not_ready", ready_int, 0);
        step();
        #1;
        check("woken_ready", ready_int, 1);
        check("woken_rs1", iss_rs1_data, 32'hAB);
        issue_int = 1;
        step();

        // Dispatch racing a matching broadcast
        set_disp(4'd3, 6'd3, 0, 6'd5, 0, 1, 0, 32'h33);
        cdb_valid = 1; cdb_tag = 5; cdb_data = 32'h55;
        step();
        #1;
        check("race_ready", ready_int, 1);
        check("race_rs1", iss_rs1_data, 32'h55);
        issue_int = 1;
        step();

        // Full queue: issue and dispatch together does not admit the new op
        for (int i = 10; i <= 13; i++) begin
            set_disp(4'(i), 6'(i), 1, 0, 32'(i), 1, 0, 32'(i));
            step();
        end
        issue_int = 1;
        set_disp(4'd14, 6'd14, 1, 0, 32'h14, 1, 0, 32'h14);
        step();
        #1;
        check("full_issue_count3", queue_full, 0);
        set_disp(4'd14, 6'd14, 1, 0, 32'h14, 1, 0, 32'h14);
        step();
        #1;
        check("refill_full", queue_full, 1);

        // Flush beats simultaneous dispatch and issue
        issue_int = 1;
        step();
        flush = 1; issue_int = 1;
        set_disp(4'd15, 6'd15, 1, 0, 32'h15, 1, 0, 32'h15);
        step();
        #1;
        check("flush_ready", ready_int, 0);
        check("flush_full", queue_full, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 1)
                set_disp(4'($urandom), 6'($urandom),
                         1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 7)), $urandom,
                         1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 7)), $urandom);
            cdb_valid = 1'($urandom_range(0, 1));
            cdb_tag   = 6'($urandom_range(0, 7));
            cdb_data  = $urandom;
            issue_int = 1'($urandom_range(0, 2) == 0);
            flush     = 1'($urandom_range(0, 49) == 0);
            step();
        end

        // Asynchronous reset mid-operation
        for (int i = 20; i < 23; i++) begin
            set_disp(4'(i), 6'(i), 1, 0, 32'(i), 1, 0, 32'(i));
            step();
        end
        rst = 0;
        #1;
        check("midrst_ready", ready_int, 0);
        check("midrst_rd_tag", iss_rd_tag, 0);
        q.delete();
        @(negedge clk);
        rst = 1;
        set_disp(4'd7, 6'd30, 1, 0, 32'h77, 1, 0, 32'h78);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
